// File: rtl/oq_pkt_store_ctrl_pkg.sv
// Shared output-queue definitions: store FSM encoding, IOQ header marker,
// and the {ctrl, data} SRAM word layout.
package oq_pkt_store_ctrl_pkg;

    // ctrl value tagging the IOQ module header word
    localparam int IO_QUEUE_STAGE_NUM = 8'hff;

    // One-hot store FSM states
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_CHECK = 4'b0010,
        ST_STORE = 4'b0100,
        ST_DROP  = 4'b1000
    } oq_store_state_t;

    // SRAM words carry ctrl in the upper bits, data in the lower bits
    function automatic int sram_word_width(input int data_w, input int ctrl_w);
        return ctrl_w + data_w;
    endfunction

endpackage

// File: rtl/oq_pkt_store_ctrl_if.sv
// SRAM write port between the packet store controller and the SRAM arbiter.
interface oq_pkt_store_ctrl_if
    import oq_pkt_store_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 19
);
    localparam int WORD_W = sram_word_width(DATA_WIDTH, CTRL_WIDTH);

    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_W-1:0]     wr_data;   // {ctrl, data}
    logic                  wr_ack;

    modport master (output wr_req, wr_addr, wr_data, input wr_ack);
    modport slave  (input wr_req, wr_addr, wr_data, output wr_ack);
endinterface

// File: rtl/oq_occupancy_tracker.sv
// Per-queue write pointer and word occupancy. Store increments and remove-side
// frees can hit the same queue in one cycle; both are folded into one update.
module oq_occupancy_tracker #(
    parameter int NUM_OUTPUT_QUEUES  = 8,
    parameter int NUM_OQ_WIDTH       = 3,
    parameter int Q_ADDR_WIDTH       = 16,
    parameter int PKT_WORD_CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          inc,
    input  logic [NUM_OQ_WIDTH-1:0]       inc_oq,
    input  logic                          rem,
    input  logic [NUM_OQ_WIDTH-1:0]       rem_oq,
    input  logic [PKT_WORD_CNT_WIDTH:0]   rem_words,
    input  logic [NUM_OQ_WIDTH-1:0]       rd_oq,
    output logic [Q_ADDR_WIDTH-1:0]       rd_wr_ptr,
    output logic [Q_ADDR_WIDTH:0]         rd_occ
);
    localparam int SW = ((Q_ADDR_WIDTH > PKT_WORD_CNT_WIDTH) ? Q_ADDR_WIDTH : PKT_WORD_CNT_WIDTH) + 2;

    logic [Q_ADDR_WIDTH-1:0]    wr_ptr  [NUM_OUTPUT_QUEUES];
    logic [Q_ADDR_WIDTH:0]      occ     [NUM_OUTPUT_QUEUES];
    logic [Q_ADDR_WIDTH:0]      occ_nxt [NUM_OUTPUT_QUEUES];
    logic [NUM_OUTPUT_QUEUES-1:0] underflow;

    assign rd_wr_ptr = wr_ptr[rd_oq];
    assign rd_occ    = occ[rd_oq];

    // Net occupancy per queue: add the stored word, subtract freed words, clamp at 0
    always_comb begin
        underflow = '0;
        for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
            logic [SW-1:0] sum;
            logic [SW-1:0] sub;
            sum = SW'(occ[i]) + SW'(inc && inc_oq == NUM_OQ_WIDTH'(i));
            sub = (rem && rem_oq == NUM_OQ_WIDTH'(i)) ? SW'(rem_words) : '0;
            if (sub > sum) begin
                occ_nxt[i]   = '0;
                underflow[i] = 1'b1;
            end else begin
                occ_nxt[i] = (Q_ADDR_WIDTH+1)'(sum - sub);
            end
        end
    end

    // Pointer/occupancy registers; pointer wraps naturally at region size
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
            if (reset) begin
                wr_ptr[i] <= '0;
                occ[i]    <= '0;
            end else begin
                if (inc && inc_oq == NUM_OQ_WIDTH'(i))
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                occ[i] <= occ_nxt[i];
            end
        end
    end

`ifndef SYNTHESIS
    // Remove side freeing more than was stored points at an accounting bug upstream
    always_ff @(posedge clk) begin
        if (!reset)
            assert (underflow == '0) else $error("oq_occupancy_tracker: removal exceeds occupancy");
    end
`endif
endmodule

// File: rtl/oq_pkt_store_ctrl.sv
// Output-queue packet store controller: takes a descriptor, checks space in the
// destination queue, then writes IOQ header through EOP into SRAM or drops it.
module oq_pkt_store_ctrl
    import oq_pkt_store_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH         = 64,
    parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int NUM_OUTPUT_QUEUES  = 8,
    parameter int Q_ADDR_WIDTH       = 16,
    parameter int PKT_WORD_CNT_WIDTH = 8,
    parameter int IOQ_STAGE_NUM      = IO_QUEUE_STAGE_NUM,
    localparam int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          dst_oq_avail,
    input  logic [NUM_OQ_WIDTH-1:0]       parsed_dst_oq,
    input  logic [PKT_WORD_CNT_WIDTH-1:0] parsed_pkt_word_len,
    output logic                          rd_dst_oq,
    input  logic [DATA_WIDTH-1:0]         in_fifo_data,
    input  logic [CTRL_WIDTH-1:0]         in_fifo_ctrl,
    input  logic                          in_fifo_empty,
    output logic                          in_fifo_rd_en,
    oq_pkt_store_ctrl_if.master           sram,
    output logic                          pkt_stored,
    output logic [NUM_OQ_WIDTH-1:0]       pkt_stored_oq,
    output logic [PKT_WORD_CNT_WIDTH:0]   pkt_stored_words,
    output logic                          pkt_dropped,
    output logic [NUM_OQ_WIDTH-1:0]       pkt_dropped_oq,
    input  logic                          pkt_removed,
    input  logic [NUM_OQ_WIDTH-1:0]       pkt_removed_oq,
    input  logic [PKT_WORD_CNT_WIDTH:0]   pkt_removed_words
);
    localparam int CMPW = ((Q_ADDR_WIDTH > PKT_WORD_CNT_WIDTH) ? Q_ADDR_WIDTH : PKT_WORD_CNT_WIDTH) + 2;

    oq_store_state_t state, state_nxt;

    logic [NUM_OQ_WIDTH-1:0]       cur_oq;
    logic [PKT_WORD_CNT_WIDTH:0]   need;
    logic [PKT_WORD_CNT_WIDTH:0]   word_cnt;
    logic                          seen_data;   // a ctrl==0 word of this packet has gone by
    logic                          hdr_seen;    // writing has started (IOQ header reached)
    logic [Q_ADDR_WIDTH-1:0]       cur_ptr;
    logic [Q_ADDR_WIDTH:0]         cur_occ;
    logic                          wr_req;
    logic                          store_word;
    logic                          head_data, head_eop, head_skip, fits;
    logic [CMPW-1:0]               free_words;

    assign head_data  = (in_fifo_ctrl == '0);
    assign head_eop   = !head_data && seen_data;
    assign head_skip  = !hdr_seen && !head_data && (in_fifo_ctrl != CTRL_WIDTH'(IOQ_STAGE_NUM));
    assign free_words = (CMPW'(1) << Q_ADDR_WIDTH) - CMPW'(cur_occ);
    assign fits       = CMPW'(need) <= free_words;
    assign store_word = (state == ST_STORE) && wr_req && sram.wr_ack;

    assign sram.wr_req  = wr_req;
    assign sram.wr_addr = {cur_oq, cur_ptr};
    assign sram.wr_data = {in_fifo_ctrl, in_fifo_data};

    oq_occupancy_tracker #(
        .NUM_OUTPUT_QUEUES (NUM_OUTPUT_QUEUES),
        .NUM_OQ_WIDTH      (NUM_OQ_WIDTH),
        .Q_ADDR_WIDTH      (Q_ADDR_WIDTH),
        .PKT_WORD_CNT_WIDTH(PKT_WORD_CNT_WIDTH)
    ) u_trk (
        .clk       (clk),
        .reset     (reset),
        .inc       (store_word),
        .inc_oq    (cur_oq),
        .rem       (pkt_removed),
        .rem_oq    (pkt_removed_oq),
        .rem_words (pkt_removed_words),
        .rd_oq     (cur_oq),
        .rd_wr_ptr (cur_ptr),
        .rd_occ    (cur_occ)
    );

    // Next state and the combinational pop/write strobes
    always_comb begin
        state_nxt     = state;
        rd_dst_oq     = 1'b0;
        in_fifo_rd_en = 1'b0;
        wr_req        = 1'b0;
        unique case (state)
            ST_IDLE: if (dst_oq_avail && !in_fifo_empty) begin
                rd_dst_oq = 1'b1;
                state_nxt = ST_CHECK;
            end
            ST_CHECK: state_nxt = fits ? ST_STORE : ST_DROP;
            ST_STORE: if (!in_fifo_empty) begin
                if (head_skip) begin
                    in_fifo_rd_en = 1'b1;
                end else begin
                    wr_req = 1'b1;
                    if (sram.wr_ack) begin
                        in_fifo_rd_en = 1'b1;
                        if (head_eop) state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: if (!in_fifo_empty) begin
                in_fifo_rd_en = 1'b1;
                if (head_eop) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (reset) begin
            rd_dst_oq     = 1'b0;
            in_fifo_rd_en = 1'b0;
            wr_req        = 1'b0;
            state_nxt     = ST_IDLE;
        end
    end

    // State, per-packet context and the registered stored/dropped pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            cur_oq           <= '0;
            need             <= '0;
            word_cnt         <= '0;
            seen_data        <= 1'b0;
            hdr_seen         <= 1'b0;
            pkt_stored       <= 1'b0;
            pkt_stored_oq    <= '0;
            pkt_stored_words <= '0;
            pkt_dropped      <= 1'b0;
            pkt_dropped_oq   <= '0;
        end else begin
            state       <= state_nxt;
            pkt_stored  <= 1'b0;
            pkt_dropped <= 1'b0;
            if (rd_dst_oq) begin
                cur_oq    <= parsed_dst_oq;
                need      <= {1'b0, parsed_pkt_word_len} + 1'b1;
                word_cnt  <= '0;
                seen_data <= 1'b0;
                hdr_seen  <= 1'b0;
            end
            if (state == ST_CHECK && !fits) begin
                pkt_dropped    <= 1'b1;
                pkt_dropped_oq <= cur_oq;
            end
            if (in_fifo_rd_en && head_data)
                seen_data <= 1'b1;
            if (store_word) begin
                word_cnt <= word_cnt + 1'b1;
                hdr_seen <= 1'b1;
                if (head_eop) begin
                    pkt_stored       <= 1'b1;
                    pkt_stored_oq    <= cur_oq;
                    pkt_stored_words <= word_cnt + 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Descriptor length must match the words actually stored
    always_ff @(posedge clk) begin
        if (!reset && store_word && head_eop)
            assert (word_cnt + 1'b1 == need) else $error("oq_pkt_store_ctrl: stored word count differs from descriptor");
    end
`endif
endmodule

// File: tb/tb_oq_pkt_store_ctrl.sv
// Bench for oq_pkt_store_ctrl: table of packets plus hand sequences for
// same-cycle removal and mid-packet reset; writes/pulses checked via scoreboard.
module tb_oq_pkt_store_ctrl;
    localparam int DW = 64, CW = 8, NQ = 8, NQW = 3, QAW = 4, PW = 8, AW = NQW + QAW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, dst_oq_avail, rd_dst_oq, in_fifo_empty, in_fifo_rd_en;
    logic [NQW-1:0] parsed_dst_oq, pkt_stored_oq, pkt_dropped_oq, pkt_removed_oq;
    logic [PW-1:0]  parsed_pkt_word_len;
    logic [DW-1:0]  in_fifo_data;
    logic [CW-1:0]  in_fifo_ctrl;
    logic pkt_stored, pkt_dropped, pkt_removed;
    logic [PW:0] pkt_stored_words, pkt_removed_words;

    oq_pkt_store_ctrl_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW)) sram ();

    oq_pkt_store_ctrl #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_OUTPUT_QUEUES(NQ),
                        .Q_ADDR_WIDTH(QAW), .PKT_WORD_CNT_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .dst_oq_avail(dst_oq_avail), .parsed_dst_oq(parsed_dst_oq),
        .parsed_pkt_word_len(parsed_pkt_word_len), .rd_dst_oq(rd_dst_oq),
        .in_fifo_data(in_fifo_data), .in_fifo_ctrl(in_fifo_ctrl), .in_fifo_empty(in_fifo_empty),
        .in_fifo_rd_en(in_fifo_rd_en), .sram(sram),
        .pkt_stored(pkt_stored), .pkt_stored_oq(pkt_stored_oq), .pkt_stored_words(pkt_stored_words),
        .pkt_dropped(pkt_dropped), .pkt_dropped_oq(pkt_dropped_oq),
        .pkt_removed(pkt_removed), .pkt_removed_oq(pkt_removed_oq), .pkt_removed_words(pkt_removed_words)
    );

    typedef struct { logic [AW-1:0] addr; logic [CW+DW-1:0] data; } wr_exp_t;
    typedef struct { bit drop; logic [NQW-1:0] oq; logic [PW:0] words; } ev_t;
    typedef struct { int q; int len; int npre; int dly; int rem_q; int rem_w; bit exp_drop; int exp_ptr; } vec_t;

    logic [CW+DW-1:0] fifo[$];
    logic [NQW+PW-1:0] desc[$];
    wr_exp_t exp_wr[$];
    ev_t     exp_ev[$];
    ev_t     cur_ev;
    vec_t    vecs[9];
    int checks = 0, errors = 0, n_wr = 0, ack_delay = 0, wait_cnt = 0, base;
    int model_occ[NQ];
    bit pop_w, pop_d, found;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        in_fifo_empty = (fifo.size() == 0);
        {in_fifo_ctrl, in_fifo_data} = (fifo.size() != 0) ? fifo[0] : '0;
        dst_oq_avail = (desc.size() != 0);
        {parsed_dst_oq, parsed_pkt_word_len} = (desc.size() != 0) ? desc[0] : '0;
    endtask

    task automatic push_pkt(input int q, input int len, input int npre, input bit drop, input int ptr);
        logic [CW+DW-1:0] w;
        wr_exp_t e;
        ev_t ev;
        for (int i = 0; i < npre; i++) fifo.push_back({CW'(8'h10 + i), DW'({$urandom, $urandom})});
        for (int k = 0; k <= len; k++) begin
            if (k == 0) w = {8'hff, 32'hC0DE0000, 32'(q * 256 + len)};
            else        w = {(k == len) ? 8'h0f : 8'h00, $urandom, $urandom};
            fifo.push_back(w);
            if (!drop) begin
                e.addr = {NQW'(q), QAW'(ptr + k)};
                e.data = w;
                exp_wr.push_back(e);
            end
        end
        ev.drop  = drop;
        ev.oq    = NQW'(q);
        ev.words = drop ? '0 : (PW+1)'(len + 1);
        exp_ev.push_back(ev);
        if (!drop) model_occ[q] += len + 1;
        desc.push_back({NQW'(q), PW'(len)});
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk); #2;
            done = (exp_ev.size() == 0) && (exp_wr.size() == 0) && (fifo.size() == 0);
        end
        chk("pkt_done_all_popped", done, 1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic do_remove(input int q, input int w);
        @(negedge clk); #2;
        pkt_removed = 1'b1; pkt_removed_oq = NQW'(q); pkt_removed_words = (PW+1)'(w);
        @(negedge clk); #2;
        pkt_removed = 1'b0;
        model_occ[q] = (model_occ[q] > w) ? model_occ[q] - w : 0;
    endtask

    task automatic run_vec(input vec_t v);
        if (v.rem_w != 0) do_remove(v.rem_q, v.rem_w);
        ack_delay = v.dly;
        push_pkt(v.q, v.len, v.npre, v.exp_drop, v.exp_ptr);
        wait_done();
        chk("occ_after_pkt", dut.u_trk.occ[v.q], model_occ[v.q]);
    endtask

    initial begin
        reset = 1'b1; pkt_removed = 1'b0; pkt_removed_oq = '0; pkt_removed_words = '0;
        sram.wr_ack = 1'b0; pop_w = 0; pop_d = 0;
        for (int i = 0; i < NQ; i++) model_occ[i] = 0;
        refresh();
        fork
            // Monitor/responder: ack generation, write scoreboard, pulse scoreboard
            forever begin
                @(negedge clk);
                if (reset) begin
                    sram.wr_ack = 1'b0; wait_cnt = 0;
                end else if (sram.wr_req) begin
                    if (wait_cnt >= ack_delay) begin sram.wr_ack = 1'b1; wait_cnt = 0; end
                    else begin sram.wr_ack = 1'b0; wait_cnt++; end
                end else begin
                    sram.wr_ack = 1'b0;
                end
                #1;
                pop_w = in_fifo_rd_en;
                pop_d = rd_dst_oq;
                if (in_fifo_rd_en) chk("pop_nonempty", in_fifo_empty, 0);
                if (sram.wr_req) begin
                    if (exp_wr.size() == 0) chk("wr_expected", exp_wr.size(), 1);
                    else begin
                        chk("wr_addr", sram.wr_addr, exp_wr[0].addr);
                        chk("wr_data", sram.wr_data, exp_wr[0].data);
                        if (sram.wr_ack) begin exp_wr.delete(0); n_wr++; end
                    end
                end
                if (pkt_stored || pkt_dropped) begin
                    if (exp_ev.size() == 0) chk("pulse_expected", exp_ev.size(), 1);
                    else begin
                        cur_ev = exp_ev[0];
                        exp_ev.delete(0);
                        chk("pulse_kind_drop", pkt_dropped, cur_ev.drop);
                        chk("pulse_exclusive", pkt_stored && pkt_dropped, 0);
                        if (cur_ev.drop) chk("dropped_oq", pkt_dropped_oq, cur_ev.oq);
                        else begin
                            chk("stored_oq", pkt_stored_oq, cur_ev.oq);
                            chk("stored_words", pkt_stored_words, cur_ev.words);
                        end
                    end
                end
            end
            // Input fifo / descriptor model: pop what the DUT consumed at this edge
            forever begin
                @(posedge clk); #1;
                if (pop_w && fifo.size() != 0) fifo.delete(0);
                if (pop_d && desc.size() != 0) desc.delete(0);
                pop_w = 0; pop_d = 0;
                refresh();
            end
        join_none

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk); #2;
        chk("rst_wr_req", sram.wr_req, 0);
        chk("rst_rd_en", in_fifo_rd_en, 0);
        chk("rst_rd_dst_oq", rd_dst_oq, 0);
        chk("rst_pkt_stored", pkt_stored, 0);
        chk("rst_pkt_dropped", pkt_dropped, 0);
        for (int i = 0; i < NQ; i++) chk("rst_occ", dut.u_trk.occ[i], 0);

        //          q  len pre dly remq remw drop ptr
        vecs[0] = '{2, 4,  0,  0,  0,   0,   0,   0};   // 5 writes {2,0..4}
        vecs[1] = '{1, 3,  1,  0,  0,   0,   0,   0};   // pre-header word skipped
        vecs[2] = '{1, 7,  0,  1,  0,   0,   0,   4};   // occ1 -> 12
        vecs[3] = '{1, 4,  2,  0,  0,   0,   1,  12};   // need 5 > free 4: drop
        vecs[4] = '{3, 13, 0,  0,  0,   0,   0,   0};   // ptr3 -> 14
        vecs[5] = '{3, 3,  0,  0,  3,  14,   0,  14};   // addrs 14,15,0,1
        vecs[6] = '{5, 2,  2,  3,  0,   0,   0,   0};   // ack after 3 wait cycles
        vecs[7] = '{0, 5,  0,  0,  0,   0,   0,   0};   // occ0 -> 6
        vecs[8] = '{1, 2,  0,  0,  1,  12,   0,  12};   // drop left ptr1 at 12
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Removal of 5 on queue 0 in the same cycle as a store ack: 6 + 1 - 5
        ack_delay = 0;
        push_pkt(0, 2, 0, 0, 6);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin @(negedge clk); #2; found = sram.wr_req; end
        chk("rem_sync_found", found, 1);
        pkt_removed = 1'b1; pkt_removed_oq = '0; pkt_removed_words = 9'd5;
        @(negedge clk); #2;
        pkt_removed = 1'b0;
        chk("occ_net_update", dut.u_trk.occ[0], 2);
        model_occ[0] -= 5;
        wait_done();
        chk("occ_after_rem", dut.u_trk.occ[0], model_occ[0]);

        // Reset after two writes of a packet: abandon it, no pulses
        push_pkt(4, 5, 0, 0, 0);
        base = n_wr; found = 0;
        for (int i = 0; i < 100 && !found; i++) begin @(posedge clk); #2; found = (n_wr - base) >= 2; end
        chk("rst_two_writes", found, 1);
        chk("rst_occ4_before", dut.u_trk.occ[4], 2);
        reset = 1'b1;
        fifo.delete(); desc.delete(); exp_wr.delete(); exp_ev.delete();
        for (int i = 0; i < NQ; i++) model_occ[i] = 0;
        @(posedge clk); #2;
        reset = 1'b0;
        for (int i = 0; i < NQ; i++) chk("midpkt_rst_occ", dut.u_trk.occ[i], 0);
        repeat (5) @(posedge clk);
        #2;
        chk("midpkt_rst_wr_req", sram.wr_req, 0);
        run_vec('{2, 2, 0, 0, 0, 0, 0, 0});   // pointers restart at 0

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
